uart_tx_datapath: RTL and testbench

UART transmitter datapath that sits directly beside the transmit FSM and is controlled by it. It captures the parallel byte, computes the parity bit, serializes the data LSB-first, and drives the single-bit `TX_OUT` line through a 4-way frame-bit selector. It consumes the FSM's `ser_en`, `mux_sel` and `Busy` outputs and returns `ser_done` to the FSM.

---
 rtl/uart_tx_datapath.sv | 107 ++++++++++
 tb/tb_uart_tx_datapath.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_datapath.sv
// -----------------------------------------------------------------------------
// uart_tx_datapath
//
// UART transmit datapath that sits beside the transmit FSM and is driven by it.
// It captures the parallel word, computes its parity bit, shifts the data out
// LSB-first and drives the serial line through a 4-way frame-bit selector.
//
// Ports
//   CLK         in   1           transmit bit clock, one frame bit per cycle
//   RST         in   1           asynchronous, active-low reset
//   P_DATA      in   DATA_WIDTH  parallel word to send
//   DATA_VALID  in   1           P_DATA valid for one cycle
//   PAR_TYP     in   1           parity type: 0 = even, 1 = odd
//   Busy        in   1           FSM frame-in-progress flag
//   ser_en      in   1           serializer enable from the FSM
//   mux_sel     in   2           frame-bit select from the FSM
//   ser_done    out  1           last data bit is being presented (combinational)
//   TX_OUT      out  1           registered serial line, idle high
//
// Handshake: a word is accepted on any rising edge where DATA_VALID=1 and
// Busy=0. There is no ready output; the FSM's Busy flag acts as the inverse
// of ready, and DATA_VALID while Busy=1 is dropped without effect.
// -----------------------------------------------------------------------------
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_TYP,
  input  logic                  Busy,
  input  logic                  ser_en,
  input  logic [1:0]            mux_sel,
  output logic                  ser_done,
  output logic                  TX_OUT
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_bit;
  logic [CW-1:0]         cnt;
  logic                  ser_data;
  logic                  tx_next;
  logic                  capture;

  assign capture = DATA_VALID & ~Busy;

  // Capture register. Parity type is sampled here only, so a PAR_TYP change
  // mid-frame cannot corrupt the parity bit already computed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg <= '0;
      par_bit  <= 1'b0;
    end else if (capture) begin
      data_reg <= P_DATA;
      par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end
  end

  // ser_done looks only at mux_sel and cnt, never at ser_en, so the FSM can
  // use it to compute ser_en without forming a combinational loop.
  assign ser_done = (mux_sel == SEL_DATA) && (cnt == LAST_BIT);
  assign ser_data = data_reg[cnt];

  // Bit counter. Leaving the data phase (or finishing it) clears the count,
  // so every frame starts at bit 0 and the counter never wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if ((mux_sel != SEL_DATA) || ser_done) begin
      cnt <= '0;
    end else if (ser_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame-bit selector.
  always_comb begin
    tx_next = 1'b1;
    case (mux_sel)
      SEL_START:  tx_next = 1'b0;
      SEL_STOP:   tx_next = 1'b1;
      SEL_DATA:   tx_next = ser_data;
      SEL_PARITY: tx_next = par_bit;
      default:    tx_next = 1'b1;
    endcase
  end

  // Registered line output; the asynchronous reset forces the line idle
  // immediately, even mid-frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
    end else begin
      TX_OUT <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_datapath
//
// Directed bench for uart_tx_datapath. The bench plays the role of the
// transmit FSM: it drives mux_sel/ser_en/Busy cycle by cycle and queues the
// hand-derived TX_OUT bit expected after each edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_datapath;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_TYP;
  logic         Busy;
  logic         ser_en;
  logic [1:0]   mux_sel;
  logic         ser_done;
  logic         TX_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  uart_tx_datapath #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_TYP    (PAR_TYP),
    .Busy       (Busy),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .ser_done   (ser_done),
    .TX_OUT     (TX_OUT)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog: every wait is on a clock edge, so this only fires on a bench bug.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // One bit-clock cycle. Called just after a rising edge: drives the FSM-side
  // inputs, checks ser_done on the falling edge, then checks TX_OUT just after
  // the next rising edge against the bit queued for this cycle.
  task automatic cycle(input logic [1:0] mux, input logic en, input logic busy,
                       input logic dv, input logic [W-1:0] pd,
                       input logic exp_tx, input logic exp_done);
    logic [0:0] e;
    mux_sel    = mux;
    ser_en     = en;
    Busy       = busy;
    DATA_VALID = dv;
    P_DATA     = pd;
    exp_q.push_back(exp_tx);
    @(negedge CLK);
    check("ser_done", 32'(ser_done), 32'(exp_done));
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("tx_out", 32'(TX_OUT), 32'(e));
  endtask

  // Full frame: idle cycle carrying DATA_VALID, start bit, data bits, optional
  // parity. exp_par is hand-computed by the caller. At data bit inj_k the bench
  // raises DATA_VALID with inj_data while Busy=1 (inj_k < 0 disables this).
  task automatic send_frame(input logic [W-1:0] data, input logic ptyp,
                            input logic pen, input logic exp_par,
                            input int inj_k, input logic [W-1:0] inj_data);
    PAR_TYP = ptyp;
    cycle(2'b01, 1'b0, 1'b0, 1'b1, data, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < W; k++) begin
      if (k == inj_k)
        cycle(2'b10, 1'b1, 1'b1, 1'b1, inj_data, data[k], 1'b0);
      else
        cycle(2'b10, 1'b1, 1'b1, 1'b0, '0, data[k], k == W - 1);
    end
    if (pen) cycle(2'b11, 1'b0, 1'b1, 1'b0, '0, exp_par, 1'b0);
  endtask

  task automatic idle_cycle();
    cycle(2'b01, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_TYP    = 1'b0;
    Busy       = 1'b0;
    ser_en     = 1'b0;
    mux_sel    = 2'b01;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx_out",   32'(TX_OUT),       32'd1);
    check("rst_data_reg", 32'(dut.data_reg), 32'd0);
    check("rst_par_bit",  32'(dut.par_bit),  32'd0);
    check("rst_cnt",      32'(dut.cnt),      32'd0);
    check("rst_ser_done", 32'(ser_done),     32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // 1. Even parity, 0xA5: 0,1,0,1,0,0,1,0,1, parity 0, then 1
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1, '0);
    idle_cycle();

    // 2. Odd parity, 0x01: data 1,0..0, parity 0, then 1.
    // PAR_TYP flips back to even mid-frame; the captured parity must hold.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1, '0);
    idle_cycle();

    // 3. Parity disabled, 0xFF: 0, eight 1s, straight back to idle
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, -1, '0);
    idle_cycle();

    // 4. Busy blocking: 0x3C offered during data bit 3 of a 0xA5 frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 3, 8'h3C);
    idle_cycle();
    check("busy_data_reg", 32'(dut.data_reg), 32'hA5);
    check("busy_par_bit",  32'(dut.par_bit),  32'd0);

    // 5. Back-to-back 0x55 then 0xAA (even parity, both 0); the second
    // DATA_VALID sits in the single idle cycle, giving one stop bit.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1, '0);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0, -1, '0);
    idle_cycle();

    // 6. Reset mid-frame on data bit 4 of 0xC3 (bit 3 on the line is 0)
    PAR_TYP = 1'b0;
    cycle(2'b01, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      cycle(2'b10, 1'b1, 1'b1, 1'b0, '0, 1'b0 ^ (k < 2), 1'b0);
    mux_sel = 2'b10;
    ser_en  = 1'b1;
    check("pre_rst_cnt", 32'(dut.cnt), 32'd4);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst_tx_out",   32'(TX_OUT),       32'd1);
    check("midrst_cnt",      32'(dut.cnt),      32'd0);
    check("midrst_data_reg", 32'(dut.data_reg), 32'd0);
    check("midrst_ser_done", 32'(ser_done),     32'd0);
    mux_sel = 2'b01;
    ser_en  = 1'b0;
    Busy    = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_hold_tx", 32'(TX_OUT), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // New 0x81 frame after reset: even parity of two ones is 0
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1, '0);
    idle_cycle();
    check("final_data_reg", 32'(dut.data_reg), 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // PAR_TYP is toggled during test 2's data phase to show it is ignored.
  initial begin
    @(posedge RST);
    wait (P_DATA == 8'h01 && DATA_VALID == 1'b1);
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    #2;
    PAR_TYP = 1'b0;
  end

endmodule
